// File: rtl/md_sigdiv_iter.sv
// md_sigdiv_iter: iterative restoring divider for the FPU significand path.
// Produces QW quotient bits (q[QW-1] has weight 2^0) plus a sticky bit for the
// rounder. A special-case operand pair bypasses iteration and completes at once.
// Build option: define MD_SIGDIV_EARLY_EXIT_EN to finish as soon as the partial
// remainder becomes zero. Results are identical, and only the latency changes.
module md_sigdiv_iter #(
  parameter int unsigned SIG_W = 53,
  parameter int unsigned QW    = SIG_W + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             kill,
  input  logic             special,
  input  logic [SIG_W-1:0] fa,
  input  logic [SIG_W-1:0] fb,
  output logic             ready,
  output logic             done,
  output logic [QW-1:0]    q,
  output logic             sticky,
  output logic             spec_o
);

  localparam int unsigned CNT_W = $clog2(QW + 1);
  localparam int unsigned REM_W = SIG_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [REM_W-1:0]   div_q, div_d;
  logic [QW-1:0]      q_q, q_d;
  logic               sticky_q, sticky_d;
  logic               spec_q, spec_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;

  logic [REM_W-1:0]   t_c;
  logic               bit_c;
  logic [REM_W-1:0]   rem_n_c;
  logic [REM_W-1:0]   rem_sh_c;
  logic [QW-1:0]      q_n_c;
  logic [CNT_W-1:0]   cnt_n_c;
`ifdef MD_SIGDIV_EARLY_EXIT_EN
  logic [CNT_W-1:0]   shamt_c;
`endif

  // One restoring step plus next-state and register updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    div_d    = div_q;
    q_d      = q_q;
    sticky_d = sticky_q;
    spec_d   = spec_q;

    t_c      = rem_q - div_q;
    bit_c    = ~t_c[SIG_W];
    rem_n_c  = bit_c ? t_c : rem_q;
    // rem_n < div keeps the top bit clear, so dropping it on the shift is lossless.
    rem_sh_c = {rem_n_c[REM_W-2:0], 1'b0};
    q_n_c    = {q_q[QW-2:0], bit_c};
    cnt_n_c  = cnt_q + CNT_W'(1);
`ifdef MD_SIGDIV_EARLY_EXIT_EN
    shamt_c  = CNT_W'(QW) - cnt_n_c;
`endif

    if (kill) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (special) begin
              state_d  = S_DONE;
              q_d      = '0;
              sticky_d = 1'b0;
              spec_d   = 1'b1;
            end else begin
              state_d  = S_RUN;
              rem_d    = {1'b0, fa};
              div_d    = {1'b0, fb};
              q_d      = '0;
              cnt_d    = '0;
              spec_d   = 1'b0;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RUN: begin
          rem_d = rem_sh_c;
          q_d   = q_n_c;
          cnt_d = cnt_n_c;
          if (cnt_n_c == CNT_W'(QW)) begin
            state_d  = S_DONE;
            sticky_d = |rem_sh_c;
          end
`ifdef MD_SIGDIV_EARLY_EXIT_EN
          else if (rem_n_c == '0) begin
            // Exact quotient: the remaining low bits would all be zero.
            state_d  = S_DONE;
            q_d      = q_n_c << shamt_c;
            sticky_d = 1'b0;
          end
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end

    done_d  = (state_d == S_DONE);
    ready_d = (state_d != S_RUN);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      q_q      <= '0;
      sticky_q <= 1'b0;
      spec_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      q_q      <= q_d;
      sticky_q <= sticky_d;
      spec_q   <= spec_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign q      = q_q;
  assign sticky = sticky_q;
  assign spec_o = spec_q;

endmodule
